// File: rtl/jpeg_rle_expander.sv
// Expands Huffman-decoded run/size/amplitude symbols into 64 zig-zag ordered
// quantized coefficients per 8x8 block, with valid/ready on both sides.
module jpeg_rle_expander #(
    parameter int COEF_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [3:0]        s_run,
    input  logic [3:0]        s_size,
    input  logic [10:0]       s_amp,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [COEF_W-1:0] m_coef,
    output logic [5:0]        m_idx,
    output logic              m_last,
    output logic              err
);

    typedef enum logic [1:0] {LOAD, ZEROS, FILL} state_t;

    state_t             state, state_n;
    logic [5:0]         idx;
    logic [3:0]         zeros_left, zeros_n;
    logic signed [12:0] pend_val, pend_val_n;
    logic               pend_vld, pend_vld_n;
    logic signed [12:0] emit_val, dec_val;
    logic               emit, slot_free, accept, size_bad, ovf, at_end;
    logic [3:0]         eff_size;

    // JPEG magnitude category decode: leading 0 bit marks a negative value
    function automatic logic signed [12:0] decode(input logic [3:0] sz, input logic [10:0] amp);
        logic [12:0] mask;
        logic [12:0] v;
        if (sz == 4'd0) return '0;
        mask = (13'd1 << sz) - 13'd1;
        v    = {2'b00, amp} & mask;
        if (v[sz - 4'd1]) return $signed(v);
        return $signed(v - mask);
    endfunction

    always_comb begin
        slot_free  = !m_valid || m_ready;
        s_ready    = (state == LOAD) && slot_free;
        accept     = s_valid && s_ready;
        size_bad   = s_size > 4'd11;
        eff_size   = size_bad ? 4'd0 : s_size;
        dec_val    = decode(eff_size, s_amp);
        at_end     = (idx == 6'd63);

        state_n    = state;
        zeros_n    = zeros_left;
        pend_val_n = pend_val;
        pend_vld_n = pend_vld;
        emit       = 1'b0;
        emit_val   = '0;
        ovf        = 1'b0;

        case (state)
            LOAD: begin
                if (accept) begin
                    emit = 1'b1;
                    if (idx == 6'd0) begin
                        emit_val = dec_val;
                    end else if (eff_size == 4'd0 && s_run == 4'd0) begin
                        state_n = FILL;
                    end else if (eff_size == 4'd0 && s_run == 4'd15) begin
                        state_n    = ZEROS;
                        zeros_n    = 4'd15;
                        pend_vld_n = 1'b0;
                        ovf        = at_end;
                    end else if (s_run == 4'd0) begin
                        emit_val = dec_val;
                    end else begin
                        state_n    = ZEROS;
                        zeros_n    = s_run - 4'd1;
                        pend_val_n = dec_val;
                        pend_vld_n = 1'b1;
                        ovf        = at_end;
                    end
                end
            end
            ZEROS: begin
                if (slot_free) begin
                    emit = 1'b1;
                    if (zeros_left != 4'd0) begin
                        zeros_n = zeros_left - 4'd1;
                        // A ZRL has nothing pending, so its last zero ends the run
                        if (zeros_left == 4'd1 && !pend_vld) state_n = LOAD;
                        ovf = at_end && (zeros_left > 4'd1 || pend_vld);
                    end else begin
                        emit_val   = pend_val;
                        pend_vld_n = 1'b0;
                        state_n    = LOAD;
                    end
                end
            end
            FILL: begin
                if (slot_free) emit = 1'b1;
            end
            default: state_n = LOAD;
        endcase

        // Emitting idx 63 closes the block; anything still queued is dropped
        if (emit && at_end) begin
            state_n    = LOAD;
            zeros_n    = '0;
            pend_vld_n = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= LOAD;
            idx        <= '0;
            zeros_left <= '0;
            pend_val   <= '0;
            pend_vld   <= 1'b0;
            m_valid    <= 1'b0;
            m_coef     <= '0;
            m_idx      <= '0;
            m_last     <= 1'b0;
            err        <= 1'b0;
        end else begin
            state      <= state_n;
            zeros_left <= zeros_n;
            pend_val   <= pend_val_n;
            pend_vld   <= pend_vld_n;
            err        <= (accept && size_bad) || ovf;
            if (emit) begin
                m_valid <= 1'b1;
                m_coef  <= COEF_W'(emit_val);
                m_idx   <= idx;
                m_last  <= at_end;
                idx     <= idx + 6'd1;
            end else if (m_ready) begin
                m_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_jpeg_rle_expander.sv
// Scoreboard bench for jpeg_rle_expander: directed symbol blocks with
// hand-computed coefficient streams checked by an independent monitor.
module tb_jpeg_rle_expander;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [3:0]  s_run = '0;
    logic [3:0]  s_size = '0;
    logic [10:0] s_amp = '0;
    logic        m_valid;
    logic        m_ready = 1'b1;
    logic [11:0] m_coef;
    logic [5:0]  m_idx;
    logic        m_last;
    logic        err;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        int coef;
        int idx;
        bit last;
        bit err;
    } exp_t;

    exp_t exp_q[$];

    jpeg_rle_expander #(.COEF_W(12)) dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_ready(s_ready),
        .s_run(s_run), .s_size(s_size), .s_amp(s_amp),
        .m_valid(m_valid), .m_ready(m_ready),
        .m_coef(m_coef), .m_idx(m_idx), .m_last(m_last), .err(err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int req);
        vectors++;
        if (act != req) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic push(input int coef, input int idx, input bit e);
        exp_t x;
        x.coef = coef;
        x.idx  = idx;
        x.last = (idx == 63);
        x.err  = e;
        exp_q.push_back(x);
    endtask

    task automatic push_zeros(input int from, input int to);
        for (int i = from; i <= to; i++) push(0, i, 1'b0);
    endtask

    // Transfers happen at the posedge following a negedge where valid&&ready
    always @(negedge clk) begin
        if (m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_output: got coef %0d idx %0d, expected none",
                         $signed(m_coef), m_idx);
            end else begin
                exp_t x;
                x = exp_q.pop_front();
                check($sformatf("coef@%0d", x.idx), int'($signed(m_coef)), x.coef);
                check($sformatf("idx@%0d", x.idx), int'(m_idx), x.idx);
                check($sformatf("last@%0d", x.idx), int'(m_last), int'(x.last));
                check($sformatf("err@%0d", x.idx), int'(err), int'(x.err));
            end
        end else if (err) begin
            vectors++;
            miscompares++;
            $display("FAIL stray_err: got err 1 without transfer, expected 0");
        end
    end

    task automatic send(input logic [3:0] run, input logic [3:0] size, input logic [10:0] amp);
        int n = 0;
        s_valid = 1'b1;
        s_run   = run;
        s_size  = size;
        s_amp   = amp;
        @(negedge clk);
        while (!s_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (!s_ready) begin
            vectors++;
            miscompares++;
            $display("FAIL send_timeout: got s_ready 0, expected 1");
        end
        @(posedge clk);
        #1;
        s_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check({name, "_drain_left"}, exp_q.size(), 0);
        exp_q.delete();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [11:0] hold_coef;
        logic [5:0]  hold_idx;
        logic        hold_last;
        int          n;

        // Reset
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_m_valid", int'(m_valid), 0);
        check("rst_m_idx", int'(m_idx), 0);
        check("rst_err", int'(err), 0);
        check("rst_s_ready", int'(s_ready), 1);

        // DC decode across two blocks: size3 amp5 -> 5, size3 amp2 -> -5
        push(5, 0, 1'b0);
        push_zeros(1, 63);
        send(4'd0, 4'd3, 11'd5);
        send(4'd0, 4'd0, 11'd0);
        drain("dc_pos");
        push(-5, 0, 1'b0);
        push_zeros(1, 63);
        send(4'd0, 4'd3, 11'd2);
        send(4'd0, 4'd0, 11'd0);
        drain("dc_neg");

        // DC 3, run 2 then -1, EOB
        push(3, 0, 1'b0);
        push(0, 1, 1'b0);
        push(0, 2, 1'b0);
        push(-1, 3, 1'b0);
        push_zeros(4, 63);
        send(4'd0, 4'd2, 11'd3);
        send(4'd2, 4'd1, 11'd0);
        send(4'd0, 4'd0, 11'd0);
        drain("eob_block");

        // Overflow: pending value 1 would land at idx 64
        push(0, 0, 1'b0);
        push_zeros(1, 62);
        push(0, 63, 1'b1);
        send(4'd0, 4'd0, 11'd0);
        repeat (3) send(4'd15, 4'd0, 11'd0);
        send(4'd15, 4'd1, 11'd1);
        drain("overflow");

        // Oversized DC flags err; block ends exactly at 63 with pending value
        push(0, 0, 1'b1);
        push_zeros(1, 62);
        push(1, 63, 1'b0);
        send(4'd0, 4'd12, 11'd7);
        repeat (3) send(4'd15, 4'd0, 11'd0);
        send(4'd14, 4'd1, 11'd1);
        drain("exact_end");

        // Backpressure mid-ZEROS: DC 1, run 10 then -2
        push(1, 0, 1'b0);
        push_zeros(1, 10);
        push(-2, 11, 1'b0);
        push_zeros(12, 63);
        send(4'd0, 4'd1, 11'd1);
        send(4'd10, 4'd2, 11'd1);
        repeat (3) @(posedge clk);
        #1;
        m_ready = 1'b0;
        @(negedge clk);
        hold_coef = m_coef;
        hold_idx  = m_idx;
        hold_last = m_last;
        check("bp_valid", int'(m_valid), 1);
        check("bp_s_ready0", int'(s_ready), 0);
        for (int i = 1; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("bp_s_ready%0d", i), int'(s_ready), 0);
            check($sformatf("bp_coef_hold%0d", i), int'(m_coef), int'(hold_coef));
            check($sformatf("bp_idx_hold%0d", i), int'(m_idx), int'(hold_idx));
            check($sformatf("bp_last_hold%0d", i), int'(m_last), int'(hold_last));
        end
        @(posedge clk);
        #1;
        m_ready = 1'b1;
        send(4'd0, 4'd0, 11'd0);
        drain("backpressure");

        // Reset during FILL at idx 20
        push(0, 0, 1'b0);
        push_zeros(1, 20);
        send(4'd0, 4'd0, 11'd0);
        send(4'd0, 4'd0, 11'd0);
        n = 0;
        @(negedge clk);
        while (!(m_valid && m_idx == 6'd20) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("mid_rst_reach_idx20", int'(m_idx), 20);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("mid_rst_m_valid", int'(m_valid), 0);
        check("mid_rst_m_idx", int'(m_idx), 0);
        check("mid_rst_queue", exp_q.size(), 0);
        push(2, 0, 1'b0);
        push_zeros(1, 63);
        send(4'd0, 4'd2, 11'd2);
        send(4'd0, 4'd0, 11'd0);
        drain("after_rst");

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
